// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter for N masters with fixed or round-robin policy.
// Grants only on an idle bus and revokes grants that never start a cycle.
module pci_bus_arbiter #(
  parameter int N_MASTERS     = 4,
  parameter int PRIORITY_MODE = 0,
  parameter int GNT_TIMEOUT   = 16,
  localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_MASTERS-1:0] req_n,
  input  logic                 frame_n,
  input  logic                 irdy_n,
  output logic [N_MASTERS-1:0] gnt_n,
  output logic [OW-1:0]        owner,
  output logic                 owner_valid
);

  localparam int CW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    BUSY
  } state_t;

  state_t                 state;
  logic [OW-1:0]          last_owner;
  logic [CW-1:0]          cnt;
  logic [OW-1:0]          winner;
  logic                   found;
  int                     j;
  logic [N_MASTERS-1:0]   own_mask;
  logic [N_MASTERS-1:0]   win_mask;
  logic                   bus_idle;
  logic                   any_req;
  logic                   others_req;

  assign bus_idle = frame_n & irdy_n;
  assign any_req  = ~&req_n;
  assign own_mask =
    {{(N_MASTERS-1){1'b0}}, 1'b1} << owner;
  assign win_mask =
    {{(N_MASTERS-1){1'b0}}, 1'b1} << winner;
  assign others_req = |(~req_n & ~own_mask);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    if (PRIORITY_MODE == 0) begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (!req_n[i]) winner = OW'(i);
      end
    end else begin
      // search starts just past the previous owner
      for (int k = 1; k <= N_MASTERS; k++) begin
        j = int'(last_owner) + k;
        if (j >= N_MASTERS) j = j - N_MASTERS;
        if (!found && !req_n[j]) begin
          winner = OW'(j);
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gnt_n       <= '1;
      owner       <= '0;
      owner_valid <= 1'b0;
      last_owner  <= OW'(N_MASTERS - 1);
      cnt         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req && bus_idle) begin
            state       <= GRANTED;
            gnt_n       <= ~win_mask;
            owner       <= winner;
            owner_valid <= 1'b1;
            cnt         <= '0;
          end
        end
        GRANTED: begin
          if (!frame_n) begin
            state <= BUSY;
          end else if (req_n[owner]) begin
            gnt_n       <= '1;
            owner_valid <= 1'b0;
            state       <= IDLE;
          end else if (cnt == CW'(GNT_TIMEOUT - 1)) begin
            gnt_n       <= '1;
            owner_valid <= 1'b0;
            last_owner  <= owner;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BUSY: begin
          if (bus_idle) begin
            gnt_n       <= '1;
            owner_valid <= 1'b0;
            last_owner  <= owner;
            state       <= IDLE;
          end else if (others_req || req_n[owner]) begin
            gnt_n       <= '1;
            owner_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pci_bus_arbiter.md
# pci_bus_arbiter

Parametrised central arbiter for the shared PCI bus. It generalises the three-master fixed-priority arbiter to N masters, with a selectable fixed-priority or round-robin policy. It tracks FRAME#/IRDY# so grants are handed off only at legal points, and it revokes grants from masters that never start a transaction. It sits beside the bus clock/reset logic and drives one active-low GNT# per master.

## Interface
- N_MASTERS, 4, number of requesting masters (2..16)
- PRIORITY_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- GNT_TIMEOUT, 16, cycles a granted master has to assert FRAME# before the grant is revoked (>= 2)
- OW, max(1, clog2(N_MASTERS)), derived width of the owner index

- clk  in  1  bus clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- req_n  in  N_MASTERS  REQ# per master, active-low
- frame_n  in  1  bus FRAME#, active-low
- irdy_n  in  1  bus IRDY#, active-low
- gnt_n  out  N_MASTERS  GNT# per master, active-low, at most one bit low
- owner  out  OW  index of the currently or last granted master
- owner_valid  out  1  high while any gnt_n bit is low

## Operation
- Bus idle means frame_n = 1 and irdy_n = 1, sampled at the edge.
- Internal registers: state, last_owner (OW bits), timeout counter of clog2(GNT_TIMEOUT+1) bits.
- States: IDLE, GRANTED, BUSY. All outputs are registered.
- Winner selection:
  - Fixed mode: the lowest index with req_n low.
  - Round-robin mode: the first requesting index strictly after last_owner, wrapping at N_MASTERS-1 → 0. A lone requester always wins, including when it equals last_owner.
- IDLE:
  - No request, or bus not idle: stay in IDLE with all gnt_n high.
  - At least one request and bus idle: go to GRANTED. Drive gnt_n[winner] low, set owner = winner and owner_valid = 1, clear the counter.
- GRANTED:
  - frame_n sampled low: go to BUSY.
  - Otherwise, req_n[owner] sampled high: drive all gnt_n high, set owner_valid = 0, go to IDLE. last_owner is unchanged.
  - Otherwise, counter reaches GNT_TIMEOUT-1: revoke the grant (all high), set last_owner = owner, go to IDLE.
  - Otherwise, increment the counter.
- BUSY (the owner is running a transaction):
  - Keep gnt_n[owner] low while req_n[owner] is low and no other req_n bit is low.
  - If any other master requests, or the owner drops its request, deassert gnt_n[owner] and set owner_valid = 0. The owner finishes its transaction.
  - Bus idle sampled: all gnt_n high, set last_owner = owner, go to IDLE.
- Grant changes between masters always pass through at least one clock with all gnt_n high. gnt_n never goes from one master directly to another.
- Simultaneous events:
  - reset beats everything.
  - In GRANTED, frame_n low beats both request withdrawal and timeout.
  - A request arriving in the same edge that BUSY returns to IDLE is arbitrated on the next IDLE edge.

## Timing
- Reset, sampled high at any edge and in any state:
  - After that edge: gnt_n = all ones, owner = 0, owner_valid = 0.
  - state = IDLE, last_owner = N_MASTERS-1, counter = 0.
- Grant latency: a request sampled at edge k while in IDLE with the bus idle gives gnt_n low after edge k (one clock).
- Release latency: owner request withdrawal in GRANTED, or a competing request in BUSY, gives gnt_n high after the same sampling edge.
- Timeout: if FRAME# has not been sampled low, the grant is high again after exactly GNT_TIMEOUT edges following the grant edge.
- Handoff: the last bus-idle edge of a transaction gives IDLE. The next grant comes one edge later, so there is a minimum of one all-high cycle.

## Test plan
- N=4, fixed mode. Assert req_n = 4'b0110 (masters 0 and 3) with the bus idle → gnt_n = 4'b1110 one clock later, owner = 0. Master 0 drives FRAME#; during BUSY, gnt_n = 4'b1111. After bus idle → one all-high cycle, then gnt_n = 4'b0111, owner = 3.
- N=4, round-robin. All four requesting continuously, each master running a 3-cycle FRAME# → grant order is 0, 1, 2, 3, 0. gnt_n never has two bits low and never switches without an all-high cycle in between.
- Timeout with GNT_TIMEOUT = 16: master 2 requests and never drives FRAME# → gnt_n[2] low for exactly 16 clocks, then high. In round-robin mode, a concurrent request from master 1 is granted next.
- Early withdrawal: master 1 is granted and raises req_n[1] before FRAME# → gnt_n = 4'b1111 after that edge and the state returns to IDLE. A subsequent request from master 1 alone is granted again.
- Same-edge events: frame_n low on the same edge the timeout expires → the grant is kept and the arbiter enters BUSY.
- Reset mid-BUSY: assert reset for one cycle → gnt_n = 4'b1111, owner = 0, owner_valid = 0. Next, in round-robin mode with all requesting, master 0 wins.
